// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared types and constants for the up/down sweep controller
package updown_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangle-sweep driver and self-checker for an up/down counter
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH      = CNT_W,
  parameter int HI_LIMIT   = 15,
  parameter int LO_LIMIT   = 0,
  parameter int NUM_SWEEPS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count,
  output logic             cntReset,
  output logic             upDown,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int SW_W = $clog2(NUM_SWEEPS + 1);

  // upDown is registered, so direction flips while the counter sits one step
  // short of each limit; the counter then lands exactly on the limit.
  localparam logic [WIDTH-1:0] HI_TURN    = WIDTH'(HI_LIMIT - 1);
  localparam logic [WIDTH-1:0] LO_TURN    = WIDTH'(LO_LIMIT + 1);
  localparam logic [WIDTH-1:0] LO_CNT     = WIDTH'(LO_LIMIT);
  localparam logic [SW_W-1:0]  SWEEP_LAST = SW_W'(NUM_SWEEPS);

  sweep_state_t     state_q, state_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             cnt_reset_q, cnt_reset_d;
  logic             up_down_q, up_down_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // Next-state: FSM, sweep accounting, expected-count tracking and checker.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    exp_d       = exp_q;
    cnt_reset_d = cnt_reset_q;
    up_down_d   = up_down_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        cnt_reset_d = 1'b1;
        up_down_d   = 1'b1;
        busy_d      = 1'b0;
        exp_d       = '0;
        sweep_d     = '0;
        if (start && !stop) begin
          state_d     = RUN;
          cnt_reset_d = 1'b0;
          busy_d      = 1'b1;
          error_d     = 1'b0;
        end
      end

      RUN: begin
        // Mirror the counter: it steps with the direction we drove last cycle.
        exp_d = up_down_q ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
        if (count != exp_q) begin
          error_d = 1'b1;
        end

        if (up_down_q && (count == HI_TURN)) begin
          up_down_d = 1'b0;
        end else if (!up_down_q && (count == LO_TURN)) begin
          up_down_d = 1'b1;
          sweep_d   = sweep_q + SW_W'(1);
        end

        // Final trough reached after the last down-turn.
        if ((sweep_q == SWEEP_LAST) && (count == LO_CNT)) begin
          state_d     = DONE;
          cnt_reset_d = 1'b1;
          up_down_d   = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end

        // Abort wins over completion; error is left as it stands.
        if (stop) begin
          state_d     = IDLE;
          cnt_reset_d = 1'b1;
          up_down_d   = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      end

      DONE: begin
        state_d     = IDLE;
        cnt_reset_d = 1'b1;
        up_down_d   = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        cnt_reset_d = 1'b1;
        up_down_d   = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sweep_q     <= '0;
      exp_q       <= '0;
      cnt_reset_q <= 1'b1;
      up_down_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      exp_q       <= exp_d;
      cnt_reset_q <= cnt_reset_d;
      up_down_q   <= up_down_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cntReset = cnt_reset_q;
  assign upDown   = up_down_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - randomized and directed bench for updown_sweep_ctrl
module tb_updown_sweep_ctrl;
  import updown_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st, sp, force_en;

  // Index 0: default parameters. Index 1: HI=6, LO=2, one sweep.
  logic       cr[2], ud[2], bz[2], dn[2], er[2];
  logic [3:0] cnt[2], cin[2];

  assign cin[0] = force_en ? 4'd3 : cnt[0];
  assign cin[1] = force_en ? 4'd3 : cnt[1];

  // The counters being driven: hold at 0 while their reset is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cnt[i] <= cr[i] ? 4'd0 : (ud[i] ? cnt[i] + 4'd1 : cnt[i] - 4'd1);
    end
  end

  updown_sweep_ctrl dut_a (
    .clock(clk), .reset(rst), .start(st), .stop(sp), .count(cin[0]),
    .cntReset(cr[0]), .upDown(ud[0]), .busy(bz[0]), .done(dn[0]), .error(er[0])
  );

  updown_sweep_ctrl #(.HI_LIMIT(6), .LO_LIMIT(2), .NUM_SWEEPS(1)) dut_b (
    .clock(clk), .reset(rst), .start(st), .stop(sp), .count(cin[1]),
    .cntReset(cr[1]), .upDown(ud[1]), .busy(bz[1]), .done(dn[1]), .error(er[1])
  );

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  bit    chk_en = 0;
  string nm[2] = '{"a", "b"};

  // Reference: the whole triangle trajectory of one run, indexed by cycles since start.
  int hi[2] = '{15, 6};
  int lo[2] = '{0, 2};
  int ns[2] = '{2, 1};
  int seq[2][128];
  int len[2];
  int ph[2];     // 0 idle, 1 running, 2 done cycle
  int t[2];      // position within seq while running
  int age[2];    // cycles the counter reset has been held
  bit me[2];     // expected error flag
  int busy_cnt[2], done_cnt[2];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic build_seq(input int i);
    int n = 0;
    for (int v = 0; v <= hi[i]; v++) begin seq[i][n] = v; n++; end
    for (int s = 1; s <= ns[i]; s++) begin
      for (int v = hi[i] - 1; v >= lo[i]; v--) begin seq[i][n] = v; n++; end
      if (s < ns[i]) begin
        for (int v = lo[i] + 1; v <= hi[i]; v++) begin seq[i][n] = v; n++; end
      end
    end
    len[i] = n;
  endtask

  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        age[i] = (ph[i] == 1) ? 0 : age[i] + 1;
        ph[i]  = 0;
        me[i]  = 1'b0;
      end else begin
        case (ph[i])
          0: begin
            if (st && !sp) begin ph[i] = 1; t[i] = 0; me[i] = 1'b0; end
            else if (age[i] < 100) age[i]++;
          end
          1: begin
            if (force_en && (seq[i][t[i]] != 3)) me[i] = 1'b1;
            if (sp) begin ph[i] = 0; age[i] = 0; end
            else begin
              t[i]++;
              if (t[i] == len[i]) begin ph[i] = 2; age[i] = 0; end
            end
          end
          default: begin ph[i] = 0; age[i]++; end
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic e_bz, e_dn, e_cr, e_ud;
    for (int i = 0; i < 2; i++) begin
      e_bz = 1'b0; e_dn = 1'b0; e_cr = 1'b1; e_ud = 1'b1;
      if (ph[i] == 1) begin
        e_bz = 1'b1; e_cr = 1'b0;
        if (t[i] + 1 < len[i]) e_ud = seq[i][t[i] + 1] > seq[i][t[i]];
        expect_eq({nm[i], ".count"}, cnt[i], seq[i][t[i]]);
      end else if (ph[i] == 2) begin
        e_dn = 1'b1;
      end else if (age[i] >= 1) begin
        expect_eq({nm[i], ".count_idle"}, cnt[i], 0);
      end
      expect_eq({nm[i], ".busy"}, bz[i], e_bz);
      expect_eq({nm[i], ".done"}, dn[i], e_dn);
      expect_eq({nm[i], ".cntReset"}, cr[i], e_cr);
      expect_eq({nm[i], ".upDown"}, ud[i], e_ud);
      expect_eq({nm[i], ".error"}, er[i], me[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    step_model();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] += int'(bz[i]);
      done_cnt[i] += int'(dn[i]);
    end
    if (chk_en) check_all();
  endtask

  task automatic pulse_start();
    st = 1'b1; cycle(); st = 1'b0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin busy_cnt[i] = 0; done_cnt[i] = 0; end
  endtask

  task automatic wait_t(input int target);
    int k = 0;
    while (!(ph[0] == 1 && t[0] == target) && k < 200) begin cycle(); k++; end
    expect_eq("wait_count", cnt[0], seq[0][target]);
  endtask

  task automatic run_to_idle(input int budget);
    int k = 0;
    while ((ph[0] != 0 || ph[1] != 0) && k < budget) begin cycle(); k++; end
    expect_eq("run_idle_busy", {31'd0, bz[0] | bz[1]}, 0);
  endtask

  initial begin
    int ft;
    rst = 1'b1; st = 1'b0; sp = 1'b0; force_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      build_seq(i); ph[i] = 0; t[i] = 0; age[i] = 0; me[i] = 1'b0;
    end
    clear_stats();

    // Reset held two clocks
    cycle(); cycle();
    expect_eq("rst.cntReset", cr[0], 1);
    expect_eq("rst.upDown", ud[0], 1);
    expect_eq("rst.busy", bz[0], 0);
    expect_eq("rst.done", dn[0], 0);
    expect_eq("rst.error", er[0], 0);
    expect_eq("rst.count", cnt[0], 0);
    rst = 1'b0;
    chk_en = 1'b1;
    cycle();

    // Full default run alongside the narrow-limit instance
    clear_stats();
    pulse_start();
    run_to_idle(100);
    cycle();
    expect_eq("t2.busy_cycles_a", busy_cnt[0], 61);
    expect_eq("t2.done_pulses_a", done_cnt[0], 1);
    expect_eq("t3.busy_cycles_b", busy_cnt[1], 11);
    expect_eq("t3.done_pulses_b", done_cnt[1], 1);

    // Stop at count 9 going up, then restart from 0
    clear_stats();
    pulse_start();
    wait_t(9);
    sp = 1'b1; cycle(); sp = 1'b0;
    cycle(); cycle();
    expect_eq("t4.no_done", done_cnt[0], 0);
    expect_eq("t4.count_zero", cnt[0], 0);
    clear_stats();
    pulse_start();
    run_to_idle(100);
    expect_eq("t4.restart_done", done_cnt[0], 1);

    // Corrupt the count seen by the checker for one cycle
    ft = $urandom_range(12, 55);
    if (ft == 27 || ft == 33) ft = 20;
    pulse_start();
    wait_t(ft);
    force_en = 1'b1; cycle(); force_en = 1'b0;
    cycle();
    expect_eq("t5.error_set", er[0], 1);
    run_to_idle(100);
    expect_eq("t5.error_sticky", er[0], 1);
    pulse_start();
    expect_eq("t5.error_cleared", er[0], 0);
    run_to_idle(100);

    // Reset mid-run at 12 going down; start with stop; start while busy
    pulse_start();
    wait_t(18);
    rst = 1'b1; cycle(); rst = 1'b0;
    expect_eq("t6.rst_busy", bz[0], 0);
    cycle();
    st = 1'b1; sp = 1'b1; cycle(); st = 1'b0; sp = 1'b0;
    cycle();
    expect_eq("t6.start_stop_busy", bz[0], 0);
    clear_stats();
    pulse_start();
    wait_t($urandom_range(2, 50));
    pulse_start();
    run_to_idle(100);
    expect_eq("t6.busy_start_done", done_cnt[0], 1);

    // Random control traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 5) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst = 1'b0; st = 1'b0; sp = 1'b0;
    run_to_idle(100);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
